// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter sharing one aes_core between N_REQ requesters: one job in flight,
// operands held stable on the core, tagged ciphertext (or timeout error) returned.
module aes_req_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [128*N_REQ-1:0]     req_plaintext,
  input  logic [128*N_REQ-1:0]     req_key,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [127:0]             rsp_data,
  output logic                     rsp_err,
  output logic                     core_start,
  output logic [127:0]             core_plaintext,
  output logic [127:0]             core_key,
  input  logic [127:0]             core_ciphertext,
  input  logic                     core_done,
  output logic                     busy
);
  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last_grant, cur_id, winner, cand;
  logic [CW-1:0]  cnt;
  logic [127:0]   sel_pt, sel_key;
  logic           done_q, done_rise, grant, found;

  // Search upward from the requester after the last winner.
  always_comb begin
    winner  = '0;
    cand    = '0;
    found   = 1'b0;
    sel_pt  = '0;
    sel_key = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == IDW'(i)) begin
        sel_pt  = req_plaintext[128*i +: 128];
        sel_key = req_key[128*i +: 128];
      end
    end
  end

  // Holding off while core_done is high lets the core return to round 0 first.
  assign grant     = (state == IDLE) && !reset && found && !core_done;
  assign done_rise = core_done & ~done_q;
  assign busy      = (state != IDLE);
  assign rsp_id    = cur_id;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT:    if (done_rise || cnt == CNT_LAST) state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q         <= 1'b0;
      cnt            <= '0;
      last_grant     <= IDW'(N_REQ - 1);
      cur_id         <= '0;
      core_plaintext <= '0;
      core_key       <= '0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
    end else begin
      done_q <= core_done;
      case (state)
        IDLE: if (grant) begin
          core_plaintext <= sel_pt;
          core_key       <= sel_key;
          cur_id         <= winner;
          last_grant     <= winner;
        end
        ISSUE: cnt <= '0;
        // A completion edge beats a timeout landing on the same cycle.
        WAIT: begin
          if (done_rise) begin
            rsp_data <= core_ciphertext;
            rsp_err  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/aes_req_arbiter.md
# aes_req_arbiter

Round-robin arbiter and sequencer that shares one `aes_core` between `N_REQ` independent requesters. It accepts one {plaintext, key} job at a time over per-requester valid/ready channels and holds the job's operands stable on the core inputs. It pulses the core start, detects completion and returns the ciphertext on a single tagged response channel. It sits between the requester front-ends and the single `aes_core` instance.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 64: maximum number of WAIT cycles before a job is failed.
- `clk  in  1`: clock.
- `reset  in  1`: asynchronous, active-high.
- `req_valid  in  N_REQ`: job offered by requester i.
- `req_ready  out  N_REQ`: one-hot accept pulse; a job transfers when `req_valid[i] & req_ready[i]`.
- `req_plaintext  in  128*N_REQ`: requester i occupies bits [128*i+127 : 128*i].
- `req_key  in  128*N_REQ`: same packing as `req_plaintext`.
- `rsp_valid  out  1`: response available.
- `rsp_ready  in  1`: consumer accepts the response.
- `rsp_id  out  $clog2(N_REQ)`: index of the requester that owns the response.
- `rsp_data  out  128`: ciphertext.
- `rsp_err  out  1`: job timed out; `rsp_data` = 0.
- `core_start  out  1`: one-cycle start pulse to `aes_core`.
- `core_plaintext  out  128`: captured operand, held stable.
- `core_key  out  128`: captured operand, held stable.
- `core_ciphertext  in  128`: ciphertext from the core.
- `core_done  in  1`: completion from the core; may stay high for several cycles.
- `busy  out  1`: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Grant condition: any `req_valid` AND `core_done == 0`.
  - Pick the winner round-robin: search upward from `last_grant+1` mod `N_REQ`.
  - Drive `req_ready[winner]` = 1 for exactly this cycle, combinationally from the registered state and `req_valid`.
  - On the clock edge: capture the winner's plaintext and key into the operand registers, set `cur_id` = winner, set `last_grant` = winner, go to ISSUE.
- **ISSUE**: `core_start` = 1 for this one cycle; go to WAIT; clear the timeout counter.
- **WAIT**
  - Register `core_done` into `done_q`. Completion is a rising edge: `core_done & ~done_q`.
  - On completion: latch `core_ciphertext` into `rsp_data`, set `rsp_err` = 0, go to RESP.
  - Otherwise the counter increments. When it reaches `TIMEOUT_CYCLES-1` with no completion: set `rsp_data` = 0, `rsp_err` = 1, go to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- **RESP**
  - `rsp_valid` = 1; `rsp_id` = `cur_id`; `rsp_data` and `rsp_err` are held constant.
  - On `rsp_ready`: go to IDLE.
- `core_plaintext` and `core_key` change only on a grant edge. They are stable from ISSUE through RESP and in the IDLE cycles that follow.
- A `core_done` edge outside WAIT is ignored, e.g. a late edge after a timeout.
- `req_ready` is 0 in every state except IDLE. Valid requests not granted stay pending with no loss and need no reordering.
- `last_grant` reset value = `N_REQ-1`, so requester 0 has first priority after reset.

## Timing
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `rsp_err` = 0.
  - `core_start` = 0, `core_plaintext` = 0, `core_key` = 0, `busy` = 0.
  - State = IDLE; counter = 0; `done_q` = 0.
- Reset mid-job aborts immediately. No response is produced and the job is lost. The core shares the same reset.
- Latency:
  - Accept edge to `core_start` high: 1 cycle.
  - `core_start` to `rsp_valid`: core latency + 1 cycle.
  - Response accept to the next possible grant: 1 cycle, since IDLE evaluates the next cycle.
- Pacing: minimum 3 cycles per job plus core latency. There is no overlap and only one job is in flight at a time.
- IDLE waits while `core_done` is high, so the core is back at round 0 before a new start is issued.

## Test plan
- FIPS-197 vector on requester 2:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff.
  - Required: `rsp_id` = 2, `rsp_data` = 69c4e0d86a7b0430d8cdb78070b4c55a, `rsp_err` = 0.
  - Required: exactly one `core_start` pulse and one `req_ready[2]` pulse.
- All 4 requesters valid continuously:
  - Required: grant order is 0,1,2,3,0.
  - Required: responses carry matching `rsp_id`; no requester starves.
- Backpressure: hold `rsp_ready` = 0 for 10 cycles in RESP.
  - Required: `rsp_valid`, `rsp_id` and `rsp_data` stay stable.
  - Required: `req_ready` stays 0; `core_start` stays 0.
- Timeout: stub core never asserts `core_done`.
  - Required: `rsp_valid` with `rsp_err` = 1 and `rsp_data` = 0 exactly 64 cycles after entering WAIT.
  - Then a late `core_done` pulse produces no response.
- Stretched done: core holds `core_done` high for 2 cycles while another request is pending.
  - Required: a single response per job.
  - Required: the next grant only in the first IDLE cycle with `core_done` = 0.
- Reset in WAIT:
  - Required: all outputs return to reset values asynchronously.
  - Required: after release, requester 0 wins when all are valid.
